// File: rtl/elev_call_latch.sv
// elev_call_latch: debounced hall/car call latching with SCAN-ordered target selection
module elev_call_latch #(
    parameter int NUM_FLOORS      = 10,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [NUM_FLOORS-1:0] buttons_inside,
    input  logic [NUM_FLOORS-2:0] buttons_outside_up,
    input  logic [NUM_FLOORS-1:1] buttons_outside_down,
    input  logic [3:0]            floor,
    input  logic                  open_door,
    input  logic                  up_signal,
    input  logic                  down_signal,
    output logic [NUM_FLOORS-1:0] lamp_inside,
    output logic [NUM_FLOORS-2:0] lamp_up,
    output logic [NUM_FLOORS-1:1] lamp_down,
    output logic [NUM_FLOORS-1:0] requests,
    output logic [3:0]            next_target,
    output logic                  target_valid,
    output logic                  dir_up
);
    // All buttons flattened: car calls low, hall-up next, hall-down on top.
    localparam int NB = 3 * NUM_FLOORS - 2;
    localparam logic [7:0] N = 8'(DEBOUNCE_CYCLES);

    logic [NB-1:0] raw, s1, s2, deb, deb_q, press, clr, lamp;
    logic [15:0] req16;
    logic [3:0] up_t, dn_t, t_nxt;
    logic has_up, has_dn, dir_nxt;

    assign raw = {buttons_outside_down, buttons_outside_up, buttons_inside};

    // Two-flop synchroniser and the previous debounced level for edge detection
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1    <= '0;
            s2    <= '0;
            deb_q <= '0;
        end else begin
            s1    <= raw;
            s2    <= s1;
            deb_q <= deb;
        end
    end

    for (genvar b = 0; b < NB; b++) begin : g_btn
        logic [7:0] cnt;
        // Count consecutive high samples, saturating so a held button stays debounced
        always_ff @(posedge clock or posedge reset) begin
            if (reset) cnt <= '0;
            else       cnt <= !s2[b] ? '0 : (cnt == N ? cnt : cnt + 8'd1);
        end
        assign deb[b] = cnt == N;
    end

    assign press = deb & ~deb_q;

    // Service clear mask: every lamp belonging to the floor the door is open at
    always_comb begin
        clr = '0;
        for (int f = 0; f < NUM_FLOORS; f++) begin
            if (open_door && floor == 4'(f)) begin
                clr[f] = 1'b1;
                if (f < NUM_FLOORS - 1) clr[NUM_FLOORS + f] = 1'b1;
                if (f > 0) clr[2 * NUM_FLOORS - 2 + f] = 1'b1;
            end
        end
    end

    // Lamps latch presses; a same-cycle clear takes priority
    always_ff @(posedge clock or posedge reset) begin
        if (reset) lamp <= '0;
        else       lamp <= (lamp | press) & ~clr;
    end

    assign lamp_inside = lamp[NUM_FLOORS-1:0];
    assign lamp_up     = lamp[2*NUM_FLOORS-2:NUM_FLOORS];
    assign lamp_down   = lamp[NB-1:2*NUM_FLOORS-1];
    assign requests    = lamp_inside | {1'b0, lamp_up} | {lamp_down, 1'b0};

    // SCAN choice: current floor, else nearest ahead, else reverse when the car is idle
    always_comb begin
        req16  = 16'(requests);
        has_up = 1'b0;
        has_dn = 1'b0;
        up_t   = '0;
        dn_t   = '0;
        for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
            if (requests[i] && 4'(i) > floor) begin
                has_up = 1'b1;
                up_t   = 4'(i);
            end
        end
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (requests[i] && 4'(i) < floor) begin
                has_dn = 1'b1;
                dn_t   = 4'(i);
            end
        end
        t_nxt   = next_target;
        dir_nxt = dir_up;
        if (req16[floor]) t_nxt = floor;
        else if (dir_up && has_up) t_nxt = up_t;
        else if (!dir_up && has_dn) t_nxt = dn_t;
        else if ((has_up || has_dn) && !up_signal && !down_signal) begin
            t_nxt   = dir_up ? dn_t : up_t;
            dir_nxt = !dir_up;
        end
    end

    // Registered target and sweep direction
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            next_target  <= '0;
            target_valid <= 1'b0;
            dir_up       <= 1'b1;
        end else begin
            next_target  <= t_nxt;
            target_valid <= |requests;
            dir_up       <= dir_nxt;
        end
    end
endmodule

// File: tb/tb_elev_call_latch.sv
// tb_elev_call_latch: directed scenarios plus random traffic against a sample-window reference model
module tb_elev_call_latch;
    localparam int NF = 10;
    localparam int N  = 4;
    localparam int NB = 3 * NF - 2;

    logic clock = 0, reset = 0;
    logic [9:0] bi = '0;
    logic [8:0] bu = '0;
    logic [9:1] bd = '0;
    logic [3:0] floor = '0;
    logic open_door = 0, up_signal = 0, down_signal = 0;
    logic [9:0] lamp_inside, requests;
    logic [8:0] lamp_up;
    logic [9:1] lamp_down;
    logic [3:0] next_target;
    logic target_valid, dir_up;
    int tests = 0, fails = 0;

    bit m_in [NF];
    bit m_up [NF];
    bit m_dn [NF];
    bit [15:0] hist [NB];
    int m_tgt = 0;
    bit m_val = 0, m_dir = 1;

    elev_call_latch #(.NUM_FLOORS(NF), .DEBOUNCE_CYCLES(N)) dut (
        .clock(clock), .reset(reset),
        .buttons_inside(bi), .buttons_outside_up(bu), .buttons_outside_down(bd),
        .floor(floor), .open_door(open_door), .up_signal(up_signal), .down_signal(down_signal),
        .lamp_inside(lamp_inside), .lamp_up(lamp_up), .lamp_down(lamp_down),
        .requests(requests), .next_target(next_target), .target_valid(target_valid), .dir_up(dir_up)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic door(input int f);
        floor = 4'(f);
        open_door = 1;
        cyc(1);
        open_door = 0;
    endtask

    // Reference model: a press happens when the raw samples taken 3..N+2 edges ago
    // were all high and the one before them was low (two sync stages, N stable samples).
    initial forever begin
        @(posedge clock or posedge reset);
        if (reset) begin
            for (int f = 0; f < NF; f++) begin
                m_in[f] = 0;
                m_up[f] = 0;
                m_dn[f] = 0;
            end
            for (int b = 0; b < NB; b++) hist[b] = '0;
            m_tgt = 0;
            m_val = 0;
            m_dir = 1;
        end else begin
            bit req [NF];
            bit any;
            int fl, hd, ho, f, g, fb;
            logic [27:0] raw;
            raw = {bd, bu, bi};
            fl = int'(floor);
            any = 0;
            for (int k = 0; k < NF; k++) begin
                req[k] = m_in[k] | (k < NF - 1 && m_up[k]) | (k > 0 && m_dn[k]);
                any |= req[k];
            end
            if (any) begin
                if (fl < NF && req[fl]) m_tgt = fl;
                else begin
                    hd = -1;
                    ho = -1;
                    for (int d = 1; d < 16; d++) begin
                        f = m_dir ? fl + d : fl - d;
                        g = m_dir ? fl - d : fl + d;
                        if (hd < 0 && f >= 0 && f < NF && req[f]) hd = f;
                        if (ho < 0 && g >= 0 && g < NF && req[g]) ho = g;
                    end
                    if (hd >= 0) m_tgt = hd;
                    else if (!up_signal && !down_signal) begin
                        m_tgt = ho;
                        m_dir = !m_dir;
                    end
                end
            end
            m_val = any;
            for (int b = 0; b < NB; b++) begin
                if ((&hist[b][N+1:2]) && !hist[b][N+2]) begin
                    if (b < NF) m_in[b] = 1;
                    else if (b < 2 * NF - 1) m_up[b - NF] = 1;
                    else begin
                        fb = b - (2 * NF - 2);
                        m_dn[fb] = 1;
                    end
                end
                hist[b] = {hist[b][14:0], raw[b]};
            end
            if (open_door && fl < NF) begin
                m_in[fl] = 0;
                m_up[fl] = 0;
                m_dn[fl] = 0;
            end
        end
    end

    // Every cycle: DUT outputs against the model
    always @(negedge clock) begin
        logic [9:0] ei, er;
        logic [8:0] eu;
        logic [9:1] ed;
        for (int f = 0; f < NF; f++) begin
            ei[f] = m_in[f];
            er[f] = m_in[f] | (f < NF - 1 && m_up[f]) | (f > 0 && m_dn[f]);
        end
        for (int f = 0; f < NF - 1; f++) eu[f] = m_up[f];
        for (int f = 1; f < NF; f++) ed[f] = m_dn[f];
        check("m_lamp_inside", lamp_inside, ei);
        check("m_lamp_up", lamp_up, eu);
        check("m_lamp_down", lamp_down, ed);
        check("m_requests", requests, er);
        check("m_next_target", next_target, m_tgt);
        check("m_target_valid", target_valid, m_val);
        check("m_dir_up", dir_up, m_dir);
    end

    initial begin
        logic [27:0] r;
        #1 reset = 1;
        @(negedge clock);
        check("rst_lamps", {lamp_inside, lamp_up, lamp_down}, 0);
        check("rst_target", next_target, 0);
        check("rst_valid", target_valid, 0);
        check("rst_dir", dir_up, 1);
        @(negedge clock);
        reset = 0;
        // Basic press: first sample at E, lamp after E+6
        bi[5] = 1;
        cyc(6);
        check("basic_lamp_early", lamp_inside, 0);
        cyc(1);
        check("basic_lamp", lamp_inside, 10'h020);
        cyc(1);
        check("basic_req", requests, 10'h020);
        check("basic_tgt", next_target, 5);
        check("basic_valid", target_valid, 1);
        check("basic_dir", dir_up, 1);
        cyc(2);
        bi[5] = 0;
        floor = 5;
        cyc(2);
        door(5);
        check("clr5_lamp", lamp_inside, 0);
        cyc(1);
        check("clr5_valid", target_valid, 0);
        check("clr5_tgt_hold", next_target, 5);
        // Glitch shorter than N samples
        floor = 3;
        bu[3] = 1;
        cyc(3);
        bu[3] = 0;
        cyc(10);
        check("glitch_lamp", lamp_up, 0);
        check("glitch_req", requests, 0);
        bu[3] = 1;
        cyc(7);
        check("hold_lamp", lamp_up, 9'h008);
        door(3);
        check("hold_cleared", lamp_up, 0);
        cyc(11);
        check("hold_single_press", lamp_up, 0);
        bu[3] = 0;
        cyc(1);
        bu[3] = 1;
        cyc(7);
        check("repress_lamp", lamp_up, 9'h008);
        bu[3] = 0;
        cyc(5);
        check("repress_stays", lamp_up, 9'h008);
        door(3);
        cyc(1);
        // Service clear of all three lamps at floor 4
        floor = 0;
        bi[4] = 1;
        bu[4] = 1;
        bd[4] = 1;
        cyc(8);
        bi[4] = 0;
        bu[4] = 0;
        bd[4] = 0;
        cyc(2);
        check("svc_in4", lamp_inside[4], 1);
        check("svc_up4", lamp_up[4], 1);
        check("svc_dn4", lamp_down[4], 1);
        check("svc_tgt", next_target, 4);
        door(4);
        check("svc_clr_in", lamp_inside[4], 0);
        check("svc_clr_up", lamp_up[4], 0);
        check("svc_clr_dn", lamp_down[4], 0);
        check("svc_clr_req", requests, 0);
        check("svc_valid_lag", target_valid, 1);
        cyc(1);
        check("svc_valid_off", target_valid, 0);
        open_door = 1;
        bi[4] = 1;
        cyc(10);
        bi[4] = 0;
        cyc(1);
        open_door = 0;
        cyc(2);
        check("svc_press_blocked", lamp_inside, 0);
        // SCAN ordering
        floor = 5;
        check("scan_dir_start", dir_up, 1);
        bi[2] = 1;
        bi[7] = 1;
        bi[9] = 1;
        cyc(8);
        bi[2] = 0;
        bi[7] = 0;
        bi[9] = 0;
        cyc(1);
        check("scan_req", requests, 10'h284);
        check("scan_t7", next_target, 7);
        door(7);
        cyc(2);
        check("scan_t9", next_target, 9);
        check("scan_dir9", dir_up, 1);
        door(9);
        cyc(2);
        check("scan_t2", next_target, 2);
        check("scan_dir_down", dir_up, 0);
        // Direction frozen while moving
        door(2);
        floor = 3;
        bi[6] = 1;
        cyc(8);
        bi[6] = 0;
        cyc(1);
        check("turn_t6", next_target, 6);
        check("turn_dir_up", dir_up, 1);
        door(6);
        floor = 3;
        up_signal = 1;
        bi[1] = 1;
        cyc(8);
        bi[1] = 0;
        cyc(2);
        check("frozen_req", requests, 10'h002);
        check("frozen_dir", dir_up, 1);
        check("frozen_tgt", next_target, 6);
        check("frozen_valid", target_valid, 1);
        up_signal = 0;
        cyc(1);
        check("unfrozen_dir", dir_up, 0);
        check("unfrozen_tgt", next_target, 1);
        // Asynchronous reset in the middle of a debounce
        bi[8] = 1;
        cyc(2);
        #2 reset = 1;
        #1;
        check("areset_lamps", {lamp_inside, lamp_up, lamp_down}, 0);
        check("areset_req", requests, 0);
        check("areset_tgt", next_target, 0);
        check("areset_valid", target_valid, 0);
        check("areset_dir", dir_up, 1);
        cyc(2);
        reset = 0;
        cyc(6);
        check("rst_press_early", lamp_inside, 0);
        cyc(1);
        check("rst_press_full", lamp_inside, 10'h100);
        bi[8] = 0;
        door(8);
        cyc(1);
        // Random traffic checked every cycle by the compare process
        repeat (3000) begin
            @(negedge clock);
            r = {bd, bu, bi};
            for (int b = 0; b < NB; b++)
                r[b] = r[b] ? ($urandom_range(0, 99) < 85) : ($urandom_range(0, 99) < 3);
            {bd, bu, bi} = r;
            if ($urandom_range(0, 7) == 0) floor = 4'($urandom_range(0, 15));
            open_door = $urandom_range(0, 99) < 15;
            up_signal = $urandom_range(0, 4) == 0;
            down_signal = !up_signal && ($urandom_range(0, 4) == 0);
        end
        bi = '0;
        bu = '0;
        bd = '0;
        open_door = 0;
        up_signal = 0;
        down_signal = 0;
        cyc(5);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/elev_call_latch.md
# elev_call_latch

Front-end request stage for the elevator controller. It synchronises and debounces the raw hall and car buttons, and latches each press into a per-button call lamp. It clears calls when the car opens its door at a floor, and exports a combined pending-request vector to the controller. It also exports a SCAN-ordered `next_target`/`target_valid` pair to the controller.

## Interface
Parameters:
- `NUM_FLOORS`, 10, number of floors; floor indices run 0..NUM_FLOORS-1.
- `DEBOUNCE_CYCLES`, 4, consecutive stable high samples needed to accept a press. Range 1..255; the counter is 8 bits.

Ports:
- `clock`  in  1  system clock, rising edge.
- `reset`  in  1  reset, asynchronous, active-high.
- `buttons_inside`  in  [9:0]  raw car buttons, asynchronous to `clock`.
- `buttons_outside_up`  in  [8:0]  raw hall-up buttons.
- `buttons_outside_down`  in  [9:1]  raw hall-down buttons.
- `floor`  in  [3:0]  current floor from the controller.
- `open_door`  in  1  door open, from the controller.
- `up_signal`, `down_signal`  in  1  car moving up / moving down, from the controller.
- `lamp_inside`  out  [9:0]  latched car calls.
- `lamp_up`  out  [8:0]  latched hall-up calls.
- `lamp_down`  out  [9:1]  latched hall-down calls.
- `requests`  out  [9:0]  per floor: lamp_inside | lamp_up | lamp_down, with missing bits treated as 0.
- `next_target`  out  [3:0]  floor selected for service.
- `target_valid`  out  1  high when `requests` is nonzero.
- `dir_up`  out  1  current sweep direction: 1 = up, 0 = down.

## Operation
- **Per-button front end (28 buttons), identical for each button:**
  - 2-flop synchroniser.
  - Stability counter: counts consecutive cycles with the synchronised value high. Clears to 0 on any low sample. Saturates at DEBOUNCE_CYCLES.
  - `deb` is 1 while the counter equals DEBOUNCE_CYCLES.
  - `press` is a 1-cycle pulse on the 0->1 edge of `deb`.
  - A held button yields exactly one `press`. It must be released (at least 1 low sample) before it can press again.
- **Lamp set:** `press` sets the corresponding lamp bit.
- **Lamp clear:** when `open_door`=1 and `floor` < NUM_FLOORS, clear `lamp_inside[floor]`, `lamp_up[floor]` (if it exists) and `lamp_down[floor]` (if it exists), every cycle the door is open.
- **Set vs clear:** if a `press` and a clear hit the same bit in the same cycle, clear wins.
- **Out-of-range floor:** `floor` >= NUM_FLOORS clears nothing.
- **`requests`:** combinational OR of the registered lamps.
- **Target selection:** registered. Evaluated every cycle from the current `requests`, `floor` and `dir_up`, in this priority order:
  1. `requests[floor]` set -> target = `floor`.
  2. Otherwise, a request exists in direction `dir_up` (strictly above for up, strictly below for down) -> target = nearest such floor.
  3. Otherwise, a request exists in the opposite direction -> target = nearest such floor, and `dir_up` toggles in the same cycle. Toggling is allowed only when `up_signal`=0 and `down_signal`=0. While moving, `dir_up` and `next_target` hold.
  4. No request -> `target_valid`=0; `next_target` and `dir_up` hold.
- **Out-of-range `floor` in target selection:** treated as no rule-1 match. Above/below comparisons use the raw 4-bit value.

## Timing
- **Reset values:** all lamps 0, `requests` 0, `next_target` 0, `target_valid` 0, `dir_up` 1. Synchroniser flops and counters are also 0.
- **Press latency:** input first sampled high at edge E with DEBOUNCE_CYCLES = N:
  - sync output high at E+1;
  - counter reaches N at E+N+1 (`deb`=1);
  - lamp and `requests` high after edge E+N+2;
  - `next_target`/`target_valid` update after edge E+N+3.
- **Glitch rejection:** a pulse shorter than N sampled cycles never sets a lamp.
- **Clear latency:** `open_door` high at edge C -> bits cleared after C. `next_target`/`target_valid` reflect the clear after C+1.
- **Reset mid-operation:** reset asserted anywhere forces all of the above reset values immediately, asynchronously. Presses in flight are discarded.

## Test plan
- **Basic press, N=4:** `buttons_inside[5]` held high 10 cycles, `floor`=0 idle -> `lamp_inside[5]`=1 exactly 6 edges after first high sample. Next cycle: `requests`=0x020, `next_target`=5, `target_valid`=1, `dir_up`=1.
- **Glitch:** `buttons_outside_up[3]` high 3 cycles then low -> no lamp, `requests` stays 0. Same button held 20 cycles -> exactly one set; bit stays 1 after release.
- **Service clear:** lamps `inside[4]`, `up[4]`, `down[4]` set, `floor`=4, `open_door` pulsed 1 cycle -> all three clear next edge, `target_valid`=0 one edge later. A press completing during `open_door` at floor 4 -> stays clear.
- **SCAN ordering:** `floor`=5, `dir_up`=1, requests at floors 2, 7, 9, idle -> `next_target`=7. Clear 7, `floor`=7 -> 9. Clear 9, idle -> `next_target`=2, `dir_up`=0.
- **Direction frozen while moving:** `up_signal`=1, `floor`=3, only request at floor 1 -> `dir_up` stays 1 and `next_target` holds. Drop `up_signal` -> `dir_up`=0, `next_target`=1 after the next edge.
- **Reset mid-debounce:** assert `reset` 2 cycles into a held press -> all outputs at reset values. After release of `reset`, a continued hold needs a full N+2 edges before the lamp sets.
